// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder. Each 32-bit word is assembled from two reads
// of a 16-bit fixed-latency backing memory. The last word is held, so repeated
// fetches of the same address are served without touching memory.
module inst_mem_responder #(
  parameter int          ADDR_WIDTH  = 32,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE    = 32'h0001_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_mem_read_en,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]           inst_data,
  output logic                  inst_mem_ready,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  inst_access_fault,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-2:0] mem_addr,
  input  logic [15:0]           mem_rdata
);

  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

  // Window limits carry one extra bit so that addr+3 near the top of the
  // address space cannot wrap back into the window.
  localparam logic [ADDR_WIDTH:0] BASE_X = (ADDR_WIDTH+1)'(MEM_BASE);
  localparam logic [ADDR_WIDTH:0] LAST_X =
    BASE_X + (ADDR_WIDTH+1)'(MEM_SIZE) - (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, LO_WAIT, HI_WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [15:0]           lo_q, lo_d;
  logic [31:0]           data_d;
  logic                  ready_d, fault_d, mem_rd_d;
  logic [ADDR_WIDTH-1:0] raddr_d;
  logic [ADDR_WIDTH-2:0] maddr_d;

  logic [ADDR_WIDTH:0]   addr_x, end_x;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  bad_addr, accept;

  // Address qualification and acceptance of a new request.
  always_comb begin
    addr_x   = {1'b0, inst_addr};
    end_x    = addr_x + (ADDR_WIDTH+1)'(3);
    offset   = inst_addr - ADDR_WIDTH'(MEM_BASE);
    bad_addr = (inst_addr[1:0] != 2'b00) || (addr_x < BASE_X) || (end_x > LAST_X);
    accept   = inst_mem_read_en &&
               ((state_q == IDLE) || ((state_q == DONE) && (inst_addr != resp_addr)));
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    data_d   = inst_data;
    ready_d  = inst_mem_ready;
    raddr_d  = resp_addr;
    fault_d  = inst_access_fault;
    mem_rd_d = 1'b0;
    maddr_d  = mem_addr;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          raddr_d = inst_addr;
          if (bad_addr) begin
            // Fault wins over any memory access: answer immediately.
            state_d = DONE;
            ready_d = 1'b1;
            fault_d = 1'b1;
            data_d  = '0;
          end else begin
            state_d  = LO_WAIT;
            ready_d  = 1'b0;
            fault_d  = 1'b0;
            mem_rd_d = 1'b1;
            maddr_d  = offset[ADDR_WIDTH-1:1];
            cnt_d    = CNT_INIT;
          end
        end
      end
      LO_WAIT: begin
        if (cnt_q == '0) begin
          lo_d     = mem_rdata;
          mem_rd_d = 1'b1;
          maddr_d  = mem_addr + (ADDR_WIDTH-1)'(1);
          cnt_d    = CNT_INIT;
          state_d  = HI_WAIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HI_WAIT: begin
        if (cnt_q == '0) begin
          data_d  = {mem_rdata, lo_q};
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      lo_q              <= '0;
      inst_data         <= '0;
      inst_mem_ready    <= 1'b0;
      resp_addr         <= '0;
      inst_access_fault <= 1'b0;
      mem_rd            <= 1'b0;
      mem_addr          <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      lo_q              <= lo_d;
      inst_data         <= data_d;
      inst_mem_ready    <= ready_d;
      resp_addr         <= raddr_d;
      inst_access_fault <= fault_d;
      mem_rd            <= mem_rd_d;
      mem_addr          <= maddr_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench: dut0 runs with WAIT_CYCLES=1, dut1 with WAIT_CYCLES=3.
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en  [2];
  logic [31:0] addr   [2];
  logic [31:0] data   [2];
  logic        rdy    [2];
  logic [31:0] raddr  [2];
  logic        flt    [2];
  logic        mrd    [2];
  logic [30:0] maddr  [2];
  logic [15:0] mrdata [2];

  typedef struct { int d; logic [31:0] data; logic [31:0] addr; logic flt; int due; } resp_t;
  typedef struct { int d; logic [30:0] ma; int due; } rd_t;

  resp_t rq[$];
  rd_t   mq[$];
  int    total = 0;
  int    bad = 0;
  int    edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  inst_mem_responder #(.WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .inst_mem_read_en(rd_en[0]), .inst_addr(addr[0]),
    .inst_data(data[0]), .inst_mem_ready(rdy[0]), .resp_addr(raddr[0]),
    .inst_access_fault(flt[0]), .mem_rd(mrd[0]), .mem_addr(maddr[0]),
    .mem_rdata(mrdata[0]));

  inst_mem_responder #(.WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .inst_mem_read_en(rd_en[1]), .inst_addr(addr[1]),
    .inst_data(data[1]), .inst_mem_ready(rdy[1]), .resp_addr(raddr[1]),
    .inst_access_fault(flt[1]), .mem_rd(mrd[1]), .mem_addr(maddr[1]),
    .mem_rdata(mrdata[1]));

  // Backing memory contents: hw0=0513, hw1=0000, else A<low 12 bits of index>.
  function automatic logic [15:0] hw(input logic [30:0] i);
    if (i == 31'd0)      return 16'h0513;
    else if (i == 31'd1) return 16'h0000;
    else                 return {4'hA, i[11:0]};
  endfunction

  // Fixed-latency memory models; data is garbage outside its valid cycle.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    localparam int W = (g == 0) ? 1 : 3;
    logic [3:0]  v = '0;
    logic [30:0] a [4];
    always @(posedge clk) begin
      v    <= {v[2:0], mrd[g]};
      a[0] <= maddr[g];
      a[1] <= a[0];
      a[2] <= a[1];
      a[3] <= a[2];
    end
    assign mrdata[g] = v[W-1] ? hw(a[W-1]) : 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pairs every mem_rd pulse and every new response with the queues.
  logic        prev_rdy   [2] = '{1'b0, 1'b0};
  logic [31:0] prev_raddr [2] = '{32'h0, 32'h0};
  always @(negedge clk) begin
    rd_t   m;
    resp_t r;
    for (int d = 0; d < 2; d++) begin
      if (mrd[d] === 1'b1) begin
        if (mq.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_rd_unexpected dut%0d: got pulse mem_addr=%h want none", d, maddr[d]);
        end else begin
          m = mq.pop_front();
          chk("mem_rd_dut", d, m.d);
          chk("mem_addr", {1'b0, maddr[d]}, {1'b0, m.ma});
          chk("mem_rd_cycle", edge_cnt, m.due);
        end
      end
      if (rdy[d] === 1'b1 && rst === 1'b0 &&
          (prev_rdy[d] !== 1'b1 || raddr[d] !== prev_raddr[d])) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected dut%0d: got addr=%h want none", d, raddr[d]);
        end else begin
          r = rq.pop_front();
          chk("resp_dut", d, r.d);
          chk("inst_data", data[d], r.data);
          chk("resp_addr", raddr[d], r.addr);
          chk("fault", {31'd0, flt[d]}, {31'd0, r.flt});
          chk("resp_cycle", edge_cnt, r.due);
        end
      end
      prev_rdy[d]   = rdy[d];
      prev_raddr[d] = raddr[d];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a request and post its expected mem_rd pulses and response.
  task automatic req(input int d, input logic [31:0] a, input logic [31:0] exp, input logic f);
    int w, e;
    w = (d == 0) ? 1 : 3;
    rd_en[d] = 1'b1;
    addr[d]  = a;
    e = edge_cnt + 1;
    rq.push_back('{d, f ? 32'h0 : exp, a, f, f ? e : e + 2*w + 2});
    if (!f) begin
      mq.push_back('{d, a[31:1], e});
      mq.push_back('{d, 31'(a[31:1] + 31'd1), e + w + 1});
    end
    tick;
  endtask

  task automatic drain;
    for (int n = 0; n < 60 && (rq.size() != 0 || mq.size() != 0); n++) tick;
    if (rq.size() != 0 || mq.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout: got %0d resp / %0d mem_rd pending want 0", rq.size(), mq.size());
      rq.delete();
      mq.delete();
    end
  endtask

  initial begin
    int e;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin rd_en[d] = 1'b0; addr[d] = '0; end
    tick; tick;
    rst = 1'b0;

    // Idle after reset: every output stays zero.
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_ready", {31'd0, rdy[0]}, 32'd0);
      chk("idle_data", data[0], 32'd0);
      chk("idle_raddr", raddr[0], 32'd0);
      chk("idle_fault", {31'd0, flt[0]}, 32'd0);
      chk("idle_mem_rd", {31'd0, mrd[0]}, 32'd0);
      chk("idle_mem_addr", {1'b0, maddr[0]}, 32'd0);
    end

    // First fetch, then held-word hits with no memory traffic.
    req(0, 32'h0, 32'h0000_0513, 1'b0);
    drain;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_ready", {31'd0, rdy[0]}, 32'd1);
      chk("hold_data", data[0], 32'h0000_0513);
    end

    // New address from DONE: ready drops next cycle.
    req(0, 32'h4, 32'hA003_A002, 1'b0);
    chk("redo_ready_drop", {31'd0, rdy[0]}, 32'd0);
    drain;

    // Last valid word of the window.
    req(0, 32'h0000_FFFC, 32'hAFFF_AFFE, 1'b0);
    drain;

    // Faults: misaligned, one past the window, top of address space.
    req(0, 32'h2, 32'h0, 1'b1);
    drain;
    req(0, 32'h0001_0000, 32'h0, 1'b1);
    drain;
    req(0, 32'hFFFF_FFFC, 32'h0, 1'b1);
    drain;

    // Address change and read_en drop while the access is in flight.
    req(0, 32'h8, 32'hA005_A004, 1'b0);
    addr[0]  = 32'h20;
    rd_en[0] = 1'b0;
    drain;

    // dut1: reset while waiting for the high half.
    e = edge_cnt + 1;
    rd_en[1] = 1'b1;
    addr[1]  = 32'h0;
    mq.push_back('{1, 31'd0, e});
    mq.push_back('{1, 31'd1, e + 4});
    tick;
    rd_en[1] = 1'b0;
    repeat (4) tick;
    chk("hi_issue_mem_rd", {31'd0, mrd[1]}, 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_ready", {31'd0, rdy[1]}, 32'd0);
      chk("rst_data", data[1], 32'd0);
      chk("rst_mem_rd", {31'd0, mrd[1]}, 32'd0);
      tick;
    end
    chk("rst_pending_mem_rd", mq.size(), 32'd0);
    req(1, 32'h0, 32'h0000_0513, 1'b0);
    drain;

    repeat (3) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
